// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Memory-stage data-access engine of the 5-stage MIPS pipeline.
//            Issues one data-bus request per load/store held in M, aligns and
//            extends returned load data, flags misaligned accesses, and raises
//            the memory-stall request to the hazard unit. An M-stage access is
//            never reissued while the pipeline is held, and a flushed access
//            that is still in flight is drained before a new one issues.
// Ports    : clk, resetn (sync, active-low)
//            M-stage inputs  : PCM, MemtoRegM, MemWriteM, SizeM, SignedM,
//                              ALUOutM, WriteDataM, StallExtM, FlushM
//            Data bus        : dreq_* (request), dresp_* (response)
//            Results         : ReadDataM, mem_stall, adel, ades, badvaddr
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] PCM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [1:0]  SizeM,
    input  logic        SignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        StallExtM,
    input  logic        FlushM,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic [31:0] ReadDataM,
    output logic        mem_stall,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REQ        = 3'd1,
        S_WAIT       = 3'd2,
        S_DONE       = 3'd3,
        S_DRAIN_REQ  = 3'd4,
        S_DRAIN_WAIT = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        w_misaligned;
    logic        w_access;
    logic [31:0] w_laneData;
    logic [3:0]  w_laneStrobe;
    logic [31:0] w_shifted;
    logic [31:0] w_loadData;

    logic        w_reqValid;
    logic        w_useHeld;
    logic        w_complete;
    logic        w_stall;
    logic        w_readBuf;

    // Request fields captured at issue; a request still waiting for addr_ok
    // must present the same fields even after the M-stage instruction that
    // launched it has been flushed and replaced.
    logic [31:0] r_reqAddr;
    logic [1:0]  r_reqSize;
    logic [3:0]  r_reqStrobe;
    logic [31:0] r_reqData;
    logic [31:0] r_readBuf;

    // PC and reset vector are carried for debug visibility only.
    logic        w_unusedDebug;
    assign w_unusedDebug = ^{PCM, RESET_PC};

    // ------------------------------------------------------------------
    // Address checks
    // ------------------------------------------------------------------
    assign w_misaligned = ((SizeM == 2'd1) & ALUOutM[0])
                        | ((SizeM == 2'd2) & (ALUOutM[1:0] != 2'b00));
    assign w_access     = (MemtoRegM | MemWriteM) & ~w_misaligned;

    // ------------------------------------------------------------------
    // Store lane replication and byte enables
    // ------------------------------------------------------------------
    always_comb begin
        w_laneData   = WriteDataM;
        w_laneStrobe = 4'b1111;
        case (SizeM)
            2'd0: begin
                w_laneData   = {4{WriteDataM[7:0]}};
                w_laneStrobe = 4'b0001 << ALUOutM[1:0];
            end
            2'd1: begin
                w_laneData   = {2{WriteDataM[15:0]}};
                w_laneStrobe = 4'b0011 << ALUOutM[1:0];
            end
            default: begin
                w_laneData   = WriteDataM;
                w_laneStrobe = 4'b1111;
            end
        endcase
        if (!MemWriteM) begin
            w_laneStrobe = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    assign w_shifted = dresp_data >> {ALUOutM[1:0], 3'b000};

    always_comb begin
        w_loadData = w_shifted;
        case (SizeM)
            2'd0:    w_loadData = {{24{SignedM & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_loadData = {{16{SignedM & w_shifted[15]}}, w_shifted[15:0]};
            default: w_loadData = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_reqValid = 1'b0;
        w_useHeld  = 1'b0;
        w_complete = 1'b0;
        w_stall    = 1'b0;
        w_readBuf  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access & ~FlushM) begin
                    w_reqValid = 1'b1;
                    if (dresp_addr_ok & dresp_data_ok) begin
                        w_complete = 1'b1;
                    end else if (dresp_addr_ok) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next = S_REQ;
                    end
                    w_stall = ~w_complete;
                end
            end
            S_REQ: begin
                w_reqValid = 1'b1;
                w_useHeld  = 1'b1;
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        if (FlushM) begin
                            w_next = S_IDLE;
                        end else begin
                            w_complete = 1'b1;
                        end
                    end else begin
                        w_next = FlushM ? S_DRAIN_WAIT : S_WAIT;
                    end
                end else if (FlushM) begin
                    w_next = S_DRAIN_REQ;
                end
                w_stall = w_access & ~w_complete;
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    if (FlushM) begin
                        w_next = S_IDLE;
                    end else begin
                        w_complete = 1'b1;
                    end
                end else if (FlushM) begin
                    w_next = S_DRAIN_WAIT;
                end
                w_stall = w_access & ~w_complete;
            end
            S_DONE: begin
                // Result already delivered; hold it until M advances.
                w_readBuf = 1'b1;
                if (FlushM | ~StallExtM) begin
                    w_next = S_IDLE;
                end
            end
            S_DRAIN_REQ: begin
                w_reqValid = 1'b1;
                w_useHeld  = 1'b1;
                w_stall    = w_access;
                if (dresp_addr_ok) begin
                    w_next = dresp_data_ok ? S_IDLE : S_DRAIN_WAIT;
                end
            end
            S_DRAIN_WAIT: begin
                w_stall = w_access;
                if (dresp_data_ok) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_complete) begin
            w_next = StallExtM ? S_DONE : S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Held request fields and load-result buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_reqAddr   <= 32'd0;
            r_reqSize   <= 2'd0;
            r_reqStrobe <= 4'd0;
            r_reqData   <= 32'd0;
            r_readBuf   <= 32'd0;
        end else begin
            if ((r_state == S_IDLE) && w_reqValid) begin
                r_reqAddr   <= ALUOutM;
                r_reqSize   <= SizeM;
                r_reqStrobe <= w_laneStrobe;
                r_reqData   <= w_laneData;
            end
            if (w_complete) begin
                r_readBuf <= MemtoRegM ? w_loadData : 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (forced quiet while reset is asserted)
    // ------------------------------------------------------------------
    assign dreq_valid  = resetn & w_reqValid;
    assign dreq_addr   = !resetn ? 32'd0 : (w_useHeld ? r_reqAddr   : ALUOutM);
    assign dreq_size   = !resetn ? 2'd0  : (w_useHeld ? r_reqSize   : SizeM);
    assign dreq_strobe = !resetn ? 4'd0  : (w_useHeld ? r_reqStrobe : w_laneStrobe);
    assign dreq_data   = !resetn ? 32'd0 : (w_useHeld ? r_reqData   : w_laneData);

    always_comb begin
        ReadDataM = 32'd0;
        if (resetn) begin
            if (w_complete && MemtoRegM) begin
                ReadDataM = w_loadData;
            end else if (w_readBuf) begin
                ReadDataM = r_readBuf;
            end
        end
    end

    assign mem_stall = resetn & w_stall;
    assign adel      = resetn & MemtoRegM & w_misaligned;
    assign ades      = resetn & MemWriteM & w_misaligned;
    assign badvaddr  = (adel | ades) ? ALUOutM : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit. Inputs change
//            1ns after the rising edge; outputs are sampled on the falling
//            edge of the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        resetn;
    logic [31:0] PCM;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic [1:0]  SizeM;
    logic        SignedM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        StallExtM;
    logic        FlushM;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;
    logic [31:0] ReadDataM;
    logic        mem_stall;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;

    int nTests;
    int nFail;
    int nAccept;

    mem_access_unit #(.RESET_PC(32'hbfc00000)) dut (
        .clk(clk), .resetn(resetn), .PCM(PCM),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .SizeM(SizeM),
        .SignedM(SignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .StallExtM(StallExtM), .FlushM(FlushM),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .ReadDataM(ReadDataM), .mem_stall(mem_stall),
        .adel(adel), .ades(ades), .badvaddr(badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted requests (valid & addr_ok at a rising edge).
    always @(posedge clk) begin
        if (resetn && dreq_valid && dresp_addr_ok) nAccept++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idleInputs();
        PCM = 32'hbfc00100; MemtoRegM = 0; MemWriteM = 0; SizeM = 2'd2;
        SignedM = 0; ALUOutM = 32'd0; WriteDataM = 32'd0; StallExtM = 0;
        FlushM = 0; dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 32'd0;
    endtask

    task automatic test_reset();
        resetn = 0; idleInputs();
        MemtoRegM = 1; ALUOutM = 32'h80000000; dresp_addr_ok = 1; dresp_data_ok = 1;
        dresp_data = 32'h55AA55AA;
        step(); step(); settle();
        nTests++; if (dreq_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid got=%b exp=0", dreq_valid); end
        nTests++; if (mem_stall !== 1'b0) begin nFail++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
        nTests++; if (ReadDataM !== 32'd0) begin nFail++; $display("FAIL reset_rdata got=%h exp=0", ReadDataM); end
        nTests++; if ({adel, ades, badvaddr} !== 34'd0) begin nFail++; $display("FAIL reset_err got=%b%b %h exp=00 0", adel, ades, badvaddr); end
        step(); idleInputs(); resetn = 1;
        step();
    endtask

    task automatic test_lw_fast();
        int a0;
        a0 = nAccept;
        MemtoRegM = 1; SizeM = 2'd2; ALUOutM = 32'h80000004;
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h12345678;
        settle();
        nTests++; if (dreq_valid !== 1'b1) begin nFail++; $display("FAIL lw_valid got=%b exp=1", dreq_valid); end
        nTests++; if (dreq_addr !== 32'h80000004 || dreq_strobe !== 4'b0000 || dreq_size !== 2'd2) begin nFail++; $display("FAIL lw_req got=%h/%b/%0d exp=80000004/0000/2", dreq_addr, dreq_strobe, dreq_size); end
        nTests++; if (mem_stall !== 1'b0) begin nFail++; $display("FAIL lw_stall got=%b exp=0", mem_stall); end
        nTests++; if (ReadDataM !== 32'h12345678) begin nFail++; $display("FAIL lw_rdata got=%h exp=12345678", ReadDataM); end
        step(); idleInputs(); settle();
        nTests++; if (dreq_valid !== 1'b0 || ReadDataM !== 32'd0) begin nFail++; $display("FAIL lw_after got=%b/%h exp=0/0", dreq_valid, ReadDataM); end
        nTests++; if (nAccept - a0 !== 1) begin nFail++; $display("FAIL lw_count got=%0d exp=1", nAccept - a0); end
        step();
    endtask

    task automatic test_lb(input logic sgn, input logic [31:0] expData);
        int a0;
        a0 = nAccept;
        MemtoRegM = 1; SizeM = 2'd0; SignedM = sgn; ALUOutM = 32'h80000003;
        settle();
        nTests++; if (dreq_valid !== 1'b1 || mem_stall !== 1'b1) begin nFail++; $display("FAIL lb_c1 valid/stall got=%b/%b exp=1/1", dreq_valid, mem_stall); end
        step(); dresp_addr_ok = 1; settle();
        nTests++; if (dreq_valid !== 1'b1 || mem_stall !== 1'b1 || dreq_addr !== 32'h80000003) begin nFail++; $display("FAIL lb_c2 valid/stall/addr got=%b/%b/%h exp=1/1/80000003", dreq_valid, mem_stall, dreq_addr); end
        step(); dresp_addr_ok = 0; settle();
        nTests++; if (dreq_valid !== 1'b0 || mem_stall !== 1'b1) begin nFail++; $display("FAIL lb_c3 valid/stall got=%b/%b exp=0/1", dreq_valid, mem_stall); end
        step(); dresp_data_ok = 1; dresp_data = 32'h80FF0000; settle();
        nTests++; if (mem_stall !== 1'b0 || dreq_valid !== 1'b0) begin nFail++; $display("FAIL lb_c4 stall/valid got=%b/%b exp=0/0", mem_stall, dreq_valid); end
        nTests++; if (ReadDataM !== expData) begin nFail++; $display("FAIL lb_rdata sgn=%b got=%h exp=%h", sgn, ReadDataM, expData); end
        nTests++; if (nAccept - a0 !== 1) begin nFail++; $display("FAIL lb_count got=%0d exp=1", nAccept - a0); end
        step(); idleInputs(); step();
    endtask

    task automatic test_store_lanes();
        int a0;
        int nValid;
        a0 = nAccept; nValid = 0;
        MemWriteM = 1; SizeM = 2'd1; ALUOutM = 32'h80000002; WriteDataM = 32'h0000ABCD;
        settle();
        nValid += int'(dreq_valid);
        nTests++; if (dreq_strobe !== 4'b1100 || dreq_data !== 32'hABCDABCD) begin nFail++; $display("FAIL sh_lanes got=%b/%h exp=1100/abcdabcd", dreq_strobe, dreq_data); end
        step(); dresp_addr_ok = 1; dresp_data_ok = 1; settle();
        nValid += int'(dreq_valid);
        nTests++; if (mem_stall !== 1'b0 || dreq_strobe !== 4'b1100) begin nFail++; $display("FAIL sh_done stall/strobe got=%b/%b exp=0/1100", mem_stall, dreq_strobe); end
        step(); idleInputs(); settle();
        nValid += int'(dreq_valid);
        nTests++; if (nAccept - a0 !== 1 || nValid !== 2) begin nFail++; $display("FAIL sh_single accepted/validCycles got=%0d/%0d exp=1/2", nAccept - a0, nValid); end
        step();
        MemWriteM = 1; SizeM = 2'd0; ALUOutM = 32'h80000101; WriteDataM = 32'hFFFFFF5A;
        dresp_addr_ok = 1; dresp_data_ok = 1; settle();
        nTests++; if (dreq_strobe !== 4'b0010 || dreq_data !== 32'h5A5A5A5A) begin nFail++; $display("FAIL sb_lanes got=%b/%h exp=0010/5a5a5a5a", dreq_strobe, dreq_data); end
        step(); idleInputs(); step();
    endtask

    task automatic test_stall_done();
        int a0;
        a0 = nAccept;
        MemtoRegM = 1; SizeM = 2'd2; ALUOutM = 32'h80000010; StallExtM = 1;
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'hCAFEF00D;
        settle();
        nTests++; if (ReadDataM !== 32'hCAFEF00D || mem_stall !== 1'b0) begin nFail++; $display("FAIL done_c1 rdata/stall got=%h/%b exp=cafef00d/0", ReadDataM, mem_stall); end
        for (int i = 0; i < 2; i++) begin
            step(); dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 32'hDEADBEEF; settle();
            nTests++; if (dreq_valid !== 1'b0 || mem_stall !== 1'b0 || ReadDataM !== 32'hCAFEF00D) begin nFail++; $display("FAIL done_hold%0d valid/stall/rdata got=%b/%b/%h exp=0/0/cafef00d", i, dreq_valid, mem_stall, ReadDataM); end
        end
        step(); StallExtM = 0; settle();
        nTests++; if (dreq_valid !== 1'b0 || ReadDataM !== 32'hCAFEF00D) begin nFail++; $display("FAIL done_exit valid/rdata got=%b/%h exp=0/cafef00d", dreq_valid, ReadDataM); end
        step(); MemtoRegM = 0; settle();
        nTests++; if (ReadDataM !== 32'd0 || nAccept - a0 !== 1) begin nFail++; $display("FAIL done_after rdata/accepted got=%h/%0d exp=0/1", ReadDataM, nAccept - a0); end
        step(); idleInputs(); step();
    endtask

    task automatic test_addr_err();
        MemtoRegM = 1; SizeM = 2'd1; ALUOutM = 32'h80000001; settle();
        nTests++; if (adel !== 1'b1 || ades !== 1'b0 || badvaddr !== 32'h80000001) begin nFail++; $display("FAIL lh_adel got=%b/%b/%h exp=1/0/80000001", adel, ades, badvaddr); end
        nTests++; if (dreq_valid !== 1'b0 || mem_stall !== 1'b0) begin nFail++; $display("FAIL lh_noreq valid/stall got=%b/%b exp=0/0", dreq_valid, mem_stall); end
        step(); MemtoRegM = 0; MemWriteM = 1; SizeM = 2'd2; ALUOutM = 32'h00000002; settle();
        nTests++; if (ades !== 1'b1 || adel !== 1'b0 || badvaddr !== 32'h00000002 || dreq_valid !== 1'b0) begin nFail++; $display("FAIL sw_ades got=%b/%b/%h/%b exp=1/0/00000002/0", ades, adel, badvaddr, dreq_valid); end
        step(); MemWriteM = 0; ALUOutM = 32'h80000003; settle();
        nTests++; if (badvaddr !== 32'd0 || adel !== 1'b0 || ades !== 1'b0) begin nFail++; $display("FAIL nomem_err got=%b/%b/%h exp=0/0/0", adel, ades, badvaddr); end
        step(); idleInputs(); step();
    endtask

    task automatic test_flush_drain();
        int a0;
        a0 = nAccept;
        MemtoRegM = 1; SizeM = 2'd2; ALUOutM = 32'h80000020; dresp_addr_ok = 1;
        step(); dresp_addr_ok = 0; FlushM = 1; settle();
        nTests++; if (dreq_valid !== 1'b0) begin nFail++; $display("FAIL flush_wait valid got=%b exp=0", dreq_valid); end
        step(); FlushM = 0; MemtoRegM = 0; MemWriteM = 1; ALUOutM = 32'h80000040; WriteDataM = 32'h11223344; settle();
        nTests++; if (dreq_valid !== 1'b0 || mem_stall !== 1'b1) begin nFail++; $display("FAIL drain_c1 valid/stall got=%b/%b exp=0/1", dreq_valid, mem_stall); end
        step(); dresp_data_ok = 1; dresp_data = 32'h99999999; settle();
        nTests++; if (dreq_valid !== 1'b0 || mem_stall !== 1'b1) begin nFail++; $display("FAIL drain_end valid/stall got=%b/%b exp=0/1", dreq_valid, mem_stall); end
        step(); dresp_data_ok = 0; settle();
        nTests++; if (dreq_valid !== 1'b1 || mem_stall !== 1'b1 || dreq_addr !== 32'h80000040 || dreq_strobe !== 4'b1111 || dreq_data !== 32'h11223344) begin nFail++; $display("FAIL sw_issue got=%b/%b/%h/%b/%h exp=1/1/80000040/1111/11223344", dreq_valid, mem_stall, dreq_addr, dreq_strobe, dreq_data); end
        step(); dresp_addr_ok = 1; dresp_data_ok = 1; settle();
        nTests++; if (mem_stall !== 1'b0) begin nFail++; $display("FAIL sw_done stall got=%b exp=0", mem_stall); end
        step(); idleInputs(); settle();
        nTests++; if (nAccept - a0 !== 2) begin nFail++; $display("FAIL drain_count got=%0d exp=2", nAccept - a0); end
        step();
    endtask

    task automatic test_reset_mid_req();
        MemtoRegM = 1; SizeM = 2'd2; ALUOutM = 32'h80000050;
        step(); resetn = 0;
        step(); settle();
        nTests++; if ({dreq_valid, mem_stall, adel, ades} !== 4'b0000 || ReadDataM !== 32'd0 || badvaddr !== 32'd0 || dreq_addr !== 32'd0) begin nFail++; $display("FAIL rst_mid got=%b%b%b%b/%h/%h/%h exp=0000/0/0/0", dreq_valid, mem_stall, adel, ades, ReadDataM, badvaddr, dreq_addr); end
        step(); resetn = 1; idleInputs(); settle();
        nTests++; if (dreq_valid !== 1'b0) begin nFail++; $display("FAIL rst_after valid got=%b exp=0", dreq_valid); end
        step(); MemtoRegM = 1; SizeM = 2'd1; SignedM = 1; ALUOutM = 32'h80000062;
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h8001FFFF; settle();
        nTests++; if (dreq_addr !== 32'h80000062 || mem_stall !== 1'b0 || ReadDataM !== 32'hFFFF8001) begin nFail++; $display("FAIL rst_newlh addr/stall/rdata got=%h/%b/%h exp=80000062/0/ffff8001", dreq_addr, mem_stall, ReadDataM); end
        step(); idleInputs(); step();
    endtask

    initial begin
        nTests = 0; nFail = 0; nAccept = 0;
        test_reset();
        test_lw_fast();
        test_lb(1'b1, 32'hFFFFFF80);
        test_lb(1'b0, 32'h00000080);
        test_store_lanes();
        test_stall_done();
        test_addr_err();
        test_flush_drain();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", nTests);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
